// File: rtl/mem_loader_if.sv
// ---------------------------------------------------------------------------
// mem_loader_if: byte-stream input, mem write port and status of the boot loader.
//
// Handshake: a byte moves on a rising clk edge exactly when in_valid and
// in_ready are both 1 in the cycle before that edge. in_data is ignored while
// in_valid is 0. A byte offered while in_ready is 0 is not consumed and must be
// held by the source until it is accepted.
//
// master: the loader (drives in_ready, the mem port and status)
// slave : the environment (drives the byte stream, observes everything else)
// ---------------------------------------------------------------------------
interface mem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, err
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, err
    );
endinterface

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader: boot-time program loader.
// Accepts CNT_LO, CNT_HI, then 2N payload bytes (16-bit little-endian words)
// and writes each word to BASE_ADDR+i through the shared mem port, keeping
// the cpu in reset until the whole image has been written.
//
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing byte
// equal to the XOR of every preceding stream byte (header included). Without
// the macro no checksum state or logic exists.
//
// o_dbg_state exposes the FSM state for checkers.
// ---------------------------------------------------------------------------
module mem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_loader_if.master bus,
    output logic [2:0]   o_dbg_state
);

    // S_CSUM is only reachable when the checksum feature is built.
    typedef enum logic [2:0] {
        S_HDR_LO  = 3'd0,
        S_HDR_HI  = 3'd1,
        S_DATA_LO = 3'd2,
        S_DATA_HI = 3'd3,
        S_FINISH  = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6,
        S_CSUM    = 3'd7
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = S_CSUM;
`else
    localparam state_t AFTER_PAYLOAD = S_FINISH;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [15:0] r_idx;
    logic [7:0]  r_lo;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic        w_in_ready;
    logic        w_xfer;
    logic [15:0] w_cnt_full;
    logic        w_last;

    // Full count as it will be once CNT_HI is latched; decides HDR_HI exit.
    assign w_cnt_full = {bus.in_data, r_cnt[7:0]};
    assign w_last     = (r_idx == (r_cnt - 16'd1));
    assign w_xfer     = bus.in_valid & w_in_ready;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR of every accepted byte; compared against the trailing byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= 8'h00;
        end else if (w_xfer) begin
            r_csum <= r_csum ^ bus.in_data;
        end
    end
`endif

    // Ready only while the loader is still collecting stream bytes.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_HDR_LO, S_HDR_HI, S_DATA_LO, S_DATA_HI: w_in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                                   w_in_ready = 1'b1;
`endif
            default:                                  w_in_ready = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR_LO;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: byte-driven except FINISH, which always moves to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR_LO: begin
                if (w_xfer) w_next = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (w_xfer) begin
                    if (w_cnt_full == 16'd0)           w_next = AFTER_PAYLOAD;
                    else if (w_cnt_full > MAX_WORDS)   w_next = S_ERR;
                    else                               w_next = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (w_xfer) w_next = S_DATA_HI;
            end
            S_DATA_HI: begin
                if (w_xfer) w_next = w_last ? AFTER_PAYLOAD : S_DATA_LO;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) w_next = (bus.in_data == r_csum) ? S_FINISH : S_ERR;
            end
`endif
            S_FINISH: w_next = S_DONE;
            default:  w_next = r_state;
        endcase
    end

    // Header/payload capture and the registered one-cycle mem write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 16'd0;
            r_idx   <= 16'd0;
            r_lo    <= 8'h00;
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_wdata <= 16'h0000;
        end else begin
            r_we <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    S_HDR_LO:  r_cnt[7:0]  <= bus.in_data;
                    S_HDR_HI:  r_cnt[15:8] <= bus.in_data;
                    S_DATA_LO: r_lo        <= bus.in_data;
                    S_DATA_HI: begin
                        r_we    <= 1'b1;
                        r_addr  <= BASE_ADDR + r_idx;
                        r_wdata <= {bus.in_data, r_lo};
                        r_idx   <= r_idx + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = r_we;
    assign bus.cpu_hold  = (r_state != S_DONE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_ERR);
    assign o_dbg_state   = r_state;

endmodule
